// File: rtl/mtm_alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mtm_alu_arbiter_pkg
// Shared definitions for the mtm ALU front end and its arbiter:
//   - opcode constants AND/OR/ADD/SUB
//   - error-flag codes ERR_DATA/ERR_CRC/ERR_OP
//   - arbiter FSM state encodings IDLE/ISSUE/WAIT/RESP
//   - slot_req_t: contents of one channel's holding slot
//   - ch_onehot(): two-channel index to one-hot response-valid mask
// ---------------------------------------------------------------------------
package mtm_alu_arbiter_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam logic [5:0] ERR_DATA = 6'b100100;
    localparam logic [5:0] ERR_CRC  = 6'b010010;
    localparam logic [5:0] ERR_OP   = 6'b001001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic        err;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [5:0]  eflg;
    } slot_req_t;

    function automatic logic [1:0] ch_onehot(input logic ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mtm_alu_req_slot.sv
// ---------------------------------------------------------------------------
// mtm_alu_req_slot
// One-deep holding register for a single requester channel.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   i_vld, i_err   1-cycle request pulses (operand frame / error frame)
//   i_a, i_b, i_op, i_eflg  request payload
//   i_release      arbiter has finished with the held request
//   o_full         slot holds a request
//   o_req          held request (err bit, operands, opcode, error flags)
//   o_ovf          sticky: a pulse arrived while full and not releasing
// ---------------------------------------------------------------------------
module mtm_alu_req_slot
    import mtm_alu_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_vld,
    input  logic        i_err,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    input  logic [5:0]  i_eflg,
    input  logic        i_release,
    output logic        o_full,
    output slot_req_t   o_req,
    output logic        o_ovf
);

    logic      w_set;
    logic      r_full;
    logic      r_ovf;
    slot_req_t r_req;

    assign w_set = i_vld | i_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
            r_req  <= '0;
        end else if (w_set && (!r_full || i_release)) begin
            // A release in the same cycle frees the slot for the new request,
            // so it is captured and the slot simply stays full.
            // An error pulse wins over a simultaneous valid pulse.
            r_full <= 1'b1;
            r_req  <= '{err: i_err, a: i_a, b: i_b, op: i_op, eflg: i_eflg};
        end else if (w_set) begin
            r_ovf  <= 1'b1;
        end else if (i_release) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_req  = r_req;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/mtm_alu_arbiter.sv
// ---------------------------------------------------------------------------
// mtm_alu_arbiter
// Shares one mtm ALU core between two serial input channels. Each channel's
// request pulse lands in a one-deep slot; a round-robin FSM issues operand
// frames to the core and returns results (or error frames, which bypass the
// core) to the owning channel.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_vld/req_err [1:0]         per-channel request pulses
//   req_a/req_b/req_op/req_eflg   {ch1,ch0} payloads
//   core_a/b/op, core_start       core issue interface
//   core_done, core_c, core_flags core result interface
//   rsp_vld [1:0]                 one-hot response valid
//   rsp_err/rsp_c/rsp_flags/rsp_eflg  response payload
//   rsp_rdy [1:0]                 per-channel response accept
//   ovf_sticky [1:0]              per-channel dropped-request flag
// Configuration:
//   MTM_ALU_ARB_TMO_EN  when defined, a response timeout of TMO_CYC cycles in
//                       WAIT returns an ERR_DATA error frame instead.
// ---------------------------------------------------------------------------
module mtm_alu_arbiter
    import mtm_alu_arbiter_pkg::*;
#(
    parameter int N_CH = 2
`ifdef MTM_ALU_ARB_TMO_EN
    , parameter int TMO_CYC = 16
`endif
) (
    input  logic [0:0]          clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     req_vld,
    input  logic [N_CH-1:0]     req_err,
    input  logic [N_CH*32-1:0]  req_a,
    input  logic [N_CH*32-1:0]  req_b,
    input  logic [N_CH*3-1:0]   req_op,
    input  logic [N_CH*6-1:0]   req_eflg,
    output logic [31:0]         core_a,
    output logic [31:0]         core_b,
    output logic [2:0]          core_op,
    output logic                core_start,
    input  logic                core_done,
    input  logic [31:0]         core_c,
    input  logic [3:0]          core_flags,
    output logic [N_CH-1:0]     rsp_vld,
    output logic                rsp_err,
    output logic [31:0]         rsp_c,
    output logic [3:0]          rsp_flags,
    output logic [5:0]          rsp_eflg,
    input  logic [N_CH-1:0]     rsp_rdy,
    output logic [N_CH-1:0]     ovf_sticky
);

    logic [N_CH-1:0] w_full;
    logic [N_CH-1:0] w_release;
    slot_req_t       w_req [N_CH];
    logic            w_pick;

    arb_state_e      r_state;
    logic            r_grant;
    logic            r_ptr;
    logic [31:0]     r_core_a;
    logic [31:0]     r_core_b;
    logic [2:0]      r_core_op;
    logic            r_core_start;
    logic [1:0]      r_rsp_vld;
    logic            r_rsp_err;
    logic [31:0]     r_rsp_c;
    logic [3:0]      r_rsp_flags;
    logic [5:0]      r_rsp_eflg;

`ifdef MTM_ALU_ARB_TMO_EN
    localparam logic [4:0] TMO_LAST = 5'(TMO_CYC - 1);
    logic [4:0]      r_tmo;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        // Only the granted channel's accept frees its slot.
        assign w_release[i] = (r_state == ST_RESP) && (r_grant == 1'(i)) && rsp_rdy[i];

        mtm_alu_req_slot u_slot (
            .clk       (clk[0]),
            .rst_n     (rst_n),
            .i_vld     (req_vld[i]),
            .i_err     (req_err[i]),
            .i_a       (req_a[i*32 +: 32]),
            .i_b       (req_b[i*32 +: 32]),
            .i_op      (req_op[i*3 +: 3]),
            .i_eflg    (req_eflg[i*6 +: 6]),
            .i_release (w_release[i]),
            .o_full    (w_full[i]),
            .o_req     (w_req[i]),
            .o_ovf     (ovf_sticky[i])
        );
    end

    // First full slot at or after the pointer; with both full the pointer wins.
    assign w_pick = w_full[r_ptr] ? r_ptr : ~r_ptr;

    always_ff @(posedge clk[0] or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_ptr        <= 1'b0;
            r_core_a     <= '0;
            r_core_b     <= '0;
            r_core_op    <= '0;
            r_core_start <= 1'b0;
            r_rsp_vld    <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_c      <= '0;
            r_rsp_flags  <= '0;
            r_rsp_eflg   <= '0;
`ifdef MTM_ALU_ARB_TMO_EN
            r_tmo        <= '0;
`endif
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_full) begin
                        r_grant <= w_pick;
                        if (w_req[w_pick].err) begin
                            // Error frames skip the core entirely.
                            r_rsp_err   <= 1'b1;
                            r_rsp_eflg  <= w_req[w_pick].eflg;
                            r_rsp_c     <= '0;
                            r_rsp_flags <= '0;
                            r_rsp_vld   <= ch_onehot(w_pick);
                            r_state     <= ST_RESP;
                        end else begin
                            r_core_a     <= w_req[w_pick].a;
                            r_core_b     <= w_req[w_pick].b;
                            r_core_op    <= w_req[w_pick].op;
                            r_core_start <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // core_start is visible during this state only.
                    r_state <= ST_WAIT;
`ifdef MTM_ALU_ARB_TMO_EN
                    r_tmo   <= '0;
`endif
                end
                ST_WAIT: begin
                    if (core_done) begin
                        r_rsp_err   <= 1'b0;
                        r_rsp_eflg  <= '0;
                        r_rsp_c     <= core_c;
                        r_rsp_flags <= core_flags;
                        r_rsp_vld   <= ch_onehot(r_grant);
                        r_state     <= ST_RESP;
                    end
`ifdef MTM_ALU_ARB_TMO_EN
                    else if (r_tmo == TMO_LAST) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_eflg  <= ERR_DATA;
                        r_rsp_c     <= '0;
                        r_rsp_flags <= '0;
                        r_rsp_vld   <= ch_onehot(r_grant);
                        r_state     <= ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + 5'd1;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_rdy[r_grant]) begin
                        r_rsp_vld <= '0;
                        r_ptr     <= ~r_grant;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign core_a     = r_core_a;
    assign core_b     = r_core_b;
    assign core_op    = r_core_op;
    assign core_start = r_core_start;
    assign rsp_vld    = r_rsp_vld;
    assign rsp_err    = r_rsp_err;
    assign rsp_c      = r_rsp_c;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_eflg   = r_rsp_eflg;

endmodule

// File: tb/tb_mtm_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mtm_alu_arbiter
// Directed bench for mtm_alu_arbiter: single issue, round-robin ties, error
// bypass, overflow drop, response hold, async reset mid-transaction and (with
// MTM_ALU_ARB_TMO_EN) the core timeout. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_mtm_alu_arbiter;
    import mtm_alu_arbiter_pkg::*;

    logic [0:0]  clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_vld, req_err;
    logic [63:0] req_a, req_b;
    logic [5:0]  req_op;
    logic [11:0] req_eflg;
    logic [31:0] core_a, core_b;
    logic [2:0]  core_op;
    logic        core_start;
    logic        core_done;
    logic [31:0] core_c;
    logic [3:0]  core_flags;
    logic [1:0]  rsp_vld;
    logic        rsp_err;
    logic [31:0] rsp_c;
    logic [3:0]  rsp_flags;
    logic [5:0]  rsp_eflg;
    logic [1:0]  rsp_rdy;
    logic [1:0]  ovf_sticky;

    int n_cmp = 0;
    int n_err = 0;

    mtm_alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_err(req_err), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_eflg(req_eflg),
        .core_a(core_a), .core_b(core_b), .core_op(core_op), .core_start(core_start),
        .core_done(core_done), .core_c(core_c), .core_flags(core_flags),
        .rsp_vld(rsp_vld), .rsp_err(rsp_err), .rsp_c(rsp_c), .rsp_flags(rsp_flags),
        .rsp_eflg(rsp_eflg), .rsp_rdy(rsp_rdy), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [5:0] e);
        req_a[ch*32 +: 32]  = a;
        req_b[ch*32 +: 32]  = b;
        req_op[ch*3 +: 3]   = op;
        req_eflg[ch*6 +: 6] = e;
    endtask

    task automatic pulse(input logic [1:0] vld, input logic [1:0] err);
        req_vld = vld;
        req_err = err;
        tick();
        req_vld = 2'b00;
        req_err = 2'b00;
    endtask

    // Advance until core_start is seen (bounded).
    task automatic wait_start(input string tag);
        int n = 0;
        while (!core_start && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(core_start), 64'd1);
    endtask

    // Serve one core transaction: check issued operand, return res, accept.
    task automatic run_core(input string tag, input logic [1:0] exp_vld,
                            input logic [31:0] exp_a, input logic [31:0] res);
        wait_start({tag, "_start"});
        chk({tag, "_core_a"}, 64'(core_a), 64'(exp_a));
        tick();
        core_done = 1'b1;
        core_c    = res;
        tick();
        core_done = 1'b0;
        chk({tag, "_rsp_vld"}, 64'(rsp_vld), 64'(exp_vld));
        chk({tag, "_rsp_c"}, 64'(rsp_c), 64'(res));
        rsp_rdy = exp_vld;
        tick();
        rsp_rdy = 2'b00;
        chk({tag, "_rsp_clr"}, 64'(rsp_vld), 64'd0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        req_vld = '0; req_err = '0; req_a = '0; req_b = '0; req_op = '0; req_eflg = '0;
        core_done = 1'b0; core_c = '0; core_flags = '0; rsp_rdy = '0;
        tick(); tick();
        chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_ovf", 64'(ovf_sticky), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: ch0 5+3, done 4 cycles after start
        set_ch(0, 32'd5, 32'd3, OP_ADD, 6'd0);
        pulse(2'b01, 2'b00);                       // now in t+1
        chk("t1_start_t1", 64'(core_start), 64'd0);
        tick();                                    // t+2
        chk("t1_start_t2", 64'(core_start), 64'd1);
        chk("t1_core_a", 64'(core_a), 64'd5);
        chk("t1_core_b", 64'(core_b), 64'd3);
        chk("t1_core_op", 64'(core_op), 64'(OP_ADD));
        tick();
        chk("t1_start_1cyc", 64'(core_start), 64'd0);
        tick(); tick(); tick();                    // t+6: done 4 cycles after start
        core_done = 1'b1; core_c = 32'd8; core_flags = 4'b0000;
        chk("t1_no_early_rsp", 64'(rsp_vld), 64'd0);
        tick();
        core_done = 1'b0;
        chk("t1_rsp_vld", 64'(rsp_vld), 64'b01);
        chk("t1_rsp_c", 64'(rsp_c), 64'd8);
        chk("t1_rsp_err", 64'(rsp_err), 64'd0);
        rsp_rdy = 2'b01;
        tick();
        rsp_rdy = 2'b00;
        chk("t1_rsp_clr", 64'(rsp_vld), 64'd0);

        // 3: ch1 error frame bypasses the core (moves pointer back to ch0)
        set_ch(1, 32'd0, 32'd0, 3'd0, ERR_CRC);
        pulse(2'b00, 2'b10);
        chk("t3_no_rsp_t1", 64'(rsp_vld), 64'd0);
        tick();
        chk("t3_rsp_vld", 64'(rsp_vld), 64'b10);
        chk("t3_rsp_err", 64'(rsp_err), 64'd1);
        chk("t3_rsp_eflg", 64'(rsp_eflg), 64'(ERR_CRC));
        chk("t3_no_start", 64'(core_start), 64'd0);
        rsp_rdy = 2'b01;                           // wrong channel, ignored
        tick();
        chk("t3_wrong_rdy", 64'(rsp_vld), 64'b10);
        rsp_rdy = 2'b10;
        tick();
        rsp_rdy = 2'b00;
        chk("t3_rsp_clr", 64'(rsp_vld), 64'd0);

        // 2: tie with pointer at ch0, twice
        set_ch(0, 32'd10, 32'd4, OP_SUB, 6'd0);
        set_ch(1, 32'd7, 32'd1, OP_AND, 6'd0);
        pulse(2'b11, 2'b00);
        run_core("t2a_ch0", 2'b01, 32'd10, 32'd6);
        run_core("t2a_ch1", 2'b10, 32'd7, 32'd1);
        set_ch(0, 32'd20, 32'd1, OP_OR, 6'd0);
        set_ch(1, 32'd30, 32'd1, OP_OR, 6'd0);
        pulse(2'b11, 2'b00);
        run_core("t2b_ch0", 2'b01, 32'd20, 32'd21);
        run_core("t2b_ch1", 2'b10, 32'd30, 32'd31);

        // 4: second ch0 request while ch0 is waiting on the core is dropped
        set_ch(0, 32'd9, 32'd9, OP_OR, 6'd0);
        pulse(2'b01, 2'b00);
        wait_start("t4_start");
        tick();
        set_ch(0, 32'd77, 32'd77, OP_ADD, 6'd0);
        pulse(2'b01, 2'b00);
        chk("t4_ovf", 64'(ovf_sticky), 64'b01);
        core_done = 1'b1; core_c = 32'd9;
        tick();
        core_done = 1'b0;
        chk("t4_rsp_vld", 64'(rsp_vld), 64'b01);
        chk("t4_rsp_c", 64'(rsp_c), 64'd9);
        rsp_rdy = 2'b01;
        tick();
        rsp_rdy = 2'b00;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (core_start || rsp_vld != 2'b00) cnt++;
            tick();
        end
        chk("t4_single_rsp", 64'(cnt), 64'd0);

        // 5: response held while rsp_rdy low; ch1 accept and stray done ignored
        set_ch(0, 32'h1000, 32'h0234, OP_ADD, 6'd0);
        pulse(2'b01, 2'b00);
        wait_start("t5_start");
        tick();
        core_done = 1'b1; core_c = 32'h1234; core_flags = 4'b0010;
        tick();
        core_done = 1'b0;
        rsp_rdy = 2'b10;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin core_done = 1'b1; core_c = 32'hdead; end
            else core_done = 1'b0;
            chk("t5_hold_vld", 64'(rsp_vld), 64'b01);
            chk("t5_hold_c", 64'(rsp_c), 64'h1234);
            tick();
        end
        core_done = 1'b0;
        chk("t5_flags", 64'(rsp_flags), 64'b0010);
        rsp_rdy = 2'b01;
        tick();
        rsp_rdy = 2'b00;
        chk("t5_rsp_clr", 64'(rsp_vld), 64'd0);

        // 6: async reset while ch1 is waiting on the core
        set_ch(1, 32'h55, 32'h1, OP_ADD, 6'd0);
        pulse(2'b10, 2'b00);
        wait_start("t6_start");
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_core_a", 64'(core_a), 64'd0);
        chk("t6_rst_ovf", 64'(ovf_sticky), 64'd0);
        chk("t6_rst_rsp_vld", 64'(rsp_vld), 64'd0);
        tick();
        rst_n = 1'b1;
        core_done = 1'b1; core_c = 32'h56;         // late done must be ignored
        tick();
        core_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (core_start || rsp_vld != 2'b00) cnt++;
            tick();
        end
        chk("t6_discarded", 64'(cnt), 64'd0);
        // pointer back to ch0 after reset
        set_ch(0, 32'd2, 32'd2, OP_ADD, 6'd0);
        set_ch(1, 32'd3, 32'd3, OP_ADD, 6'd0);
        pulse(2'b11, 2'b00);
        run_core("t6_ch0", 2'b01, 32'd2, 32'd4);
        run_core("t6_ch1", 2'b10, 32'd3, 32'd6);

`ifdef MTM_ALU_ARB_TMO_EN
        set_ch(0, 32'd1, 32'd1, OP_ADD, 6'd0);
        pulse(2'b01, 2'b00);
        wait_start("tmo_start");
        cnt = 0;
        while (rsp_vld == 2'b00 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("tmo_rsp_vld", 64'(rsp_vld), 64'b01);
        chk("tmo_rsp_err", 64'(rsp_err), 64'd1);
        chk("tmo_rsp_eflg", 64'(rsp_eflg), 64'(ERR_DATA));
        chk("tmo_rsp_c", 64'(rsp_c), 64'd0);
        rsp_rdy = 2'b01;
        tick();
        rsp_rdy = 2'b00;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
